// File: rtl/int_vec_ctrl.sv
// Purpose : vectored, prioritised, nestable interrupt controller beside the hardwired sequencer.
// Latency : irq rising edge -> pending on the next t3 edge -> int_req combinationally in that same cycle.
// Backpres: int_req is held until int_ack; it is withheld while disabled, not preempting, or the stack is full.
//
// Ports:
//   t3 / clr            clock (rising edge) / asynchronous active-high reset
//   irq                 request lines; a rising edge latches a pending request
//   int_ack / iret      sequencer accepts the current request / return from interrupt
//   ei / di             set / clear global enable
//   mask_we/mask_wdata  mask write (1 = source masked)
//   int_req/int_vec/int_id  request, entry PC and index of the winning source
//   en_int, pending, in_service, nest_depth  architectural state visible to the sequencer
module int_vec_ctrl #(
    parameter int                NUM_SRC    = 4,
    parameter int                NEST_DEPTH = 2,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 8'hE0,
    parameter int                VEC_STRIDE = 4
) (
    input  logic               t3,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               int_ack,
    input  logic               iret,
    input  logic               ei,
    input  logic               di,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic               int_req,
    output logic [ADDR_W-1:0]  int_vec,
    output logic [2:0]         int_id,
    output logic               en_int,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output logic [2:0]         nest_depth
);

    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] ret_clr;
    logic [2:0]         stack [NEST_DEPTH];
    logic [2:0]         cand;
    logic [2:0]         top_id;
    logic               cand_valid;
    logic               preempt_ok;
    logic               accept;
    logic               pop;
    logic [31:0]        vec_full;

    // Fixed priority: scan downwards so the lowest eligible index wins.
    always_comb begin
        cand       = 3'd0;
        cand_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i] && !mask[i]) begin
                cand       = 3'(i);
                cand_valid = 1'b1;
            end
        end
    end

    // Top of stack is the entry just below nest_depth; empty stack matches no entry.
    always_comb begin
        top_id = 3'd0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (3'(i) == nest_depth - 3'd1) begin
                top_id = stack[i];
            end
        end
    end

    assign preempt_ok = (nest_depth == 3'd0) || (cand < top_id);
    assign int_req    = en_int & cand_valid & preempt_ok & (nest_depth < 3'(NEST_DEPTH));
    // iret wins over a simultaneous ack so a protocol error cannot push and pop at once.
    assign accept     = int_ack & int_req & ~iret;
    assign pop        = iret & (nest_depth != 3'd0);
    assign rise       = irq & ~irq_q;
    assign ack_clr    = accept ? (NUM_SRC'(1) << cand) : '0;
    assign ret_clr    = pop ? (NUM_SRC'(1) << top_id) : '0;

    assign vec_full = 32'(VEC_BASE) + 32'(cand) * 32'(VEC_STRIDE);
    assign int_vec  = vec_full[ADDR_W-1:0];
    assign int_id   = cand;

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= '1;
            en_int     <= 1'b1;
            nest_depth <= 3'd0;
            irq_q      <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack[i] <= 3'd0;
            end
        end else begin
            irq_q <= irq;
            // A fresh edge on the acknowledged source in the same cycle keeps it pending.
            pending    <= (pending & ~ack_clr) | rise;
            in_service <= (in_service | ack_clr) & ~ret_clr;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (accept) begin
                nest_depth <= nest_depth + 3'd1;
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    if (3'(i) == nest_depth) begin
                        stack[i] <= cand;
                    end
                end
            end else if (pop) begin
                nest_depth <= nest_depth - 3'd1;
            end
            if (accept) begin
                en_int <= 1'b0;
            end else if (di) begin
                en_int <= 1'b0;
            end else if (iret || ei) begin
                en_int <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_vec_ctrl.sv
module tb_int_vec_ctrl;

    logic       t3 = 1'b0;
    logic       clr;
    logic [3:0] irq;
    logic       int_ack, iret, ei, di, mask_we;
    logic [3:0] mask_wdata;
    logic       int_req;
    logic [7:0] int_vec;
    logic [2:0] int_id;
    logic       en_int;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [2:0] nest_depth;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain bit sets plus a queue used as the nesting stack.
    bit [3:0] m_pend, m_mask, m_prev;
    bit       m_en;
    int       m_stk[$];

    int_vec_ctrl dut (
        .t3(t3), .clr(clr), .irq(irq), .int_ack(int_ack), .iret(iret),
        .ei(ei), .di(di), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_req(int_req), .int_vec(int_vec), .int_id(int_id), .en_int(en_int),
        .pending(pending), .in_service(in_service), .nest_depth(nest_depth)
    );

    always #5 t3 = ~t3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_pend = '0;
        m_mask = '1;
        m_prev = '0;
        m_en   = 1'b1;
        m_stk.delete();
    endfunction

    function automatic int m_cand();
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && !m_mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_req();
        int c = m_cand();
        if (!m_en || c < 0 || m_stk.size() >= 2) return 1'b0;
        if (m_stk.size() == 0) return 1'b1;
        return c < m_stk[$];
    endfunction

    function automatic void m_update();
        int c   = m_cand();
        bit acc = int_ack && m_req() && !iret;
        if (acc) begin
            m_pend[c] = 1'b0;
            m_stk.push_back(c);
        end
        if (acc)              m_en = 1'b0;
        else if (di)          m_en = 1'b0;
        else if (iret || ei)  m_en = 1'b1;
        if (iret && m_stk.size() > 0) void'(m_stk.pop_back());
        m_pend = m_pend | (irq & ~m_prev);
        m_prev = irq;
        if (mask_we) m_mask = mask_wdata;
    endfunction

    task automatic check_all();
        int       c = m_cand();
        bit       r = m_req();
        bit [3:0] isv = '0;
        bit [7:0] ev;
        foreach (m_stk[k]) isv[m_stk[k]] = 1'b1;
        chk("int_req", 32'(int_req), 32'(r));
        if (r) begin
            ev = 8'(32'hE0 + 32'(c) * 4);
            chk("int_vec", 32'(int_vec), 32'(ev));
            chk("int_id", 32'(int_id), 32'(c));
        end
        chk("en_int", 32'(en_int), 32'(m_en));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("in_service", 32'(in_service), 32'(isv));
        chk("nest_depth", 32'(nest_depth), 32'(m_stk.size()));
    endtask

    task automatic tick();
        check_all();
        @(posedge t3);
        if (clr) m_reset();
        else     m_update();
        #1;
        int_ack = 1'b0; iret = 1'b0; ei = 1'b0; di = 1'b0; mask_we = 1'b0;
    endtask

    task automatic reset_consts(input string tag);
        chk({tag, "_req"}, 32'(int_req), 32'd0);
        chk({tag, "_vec"}, 32'(int_vec), 32'hE0);
        chk({tag, "_id"}, 32'(int_id), 32'd0);
        chk({tag, "_en"}, 32'(en_int), 32'd1);
        chk({tag, "_pend"}, 32'(pending), 32'd0);
        chk({tag, "_isv"}, 32'(in_service), 32'd0);
        chk({tag, "_depth"}, 32'(nest_depth), 32'd0);
    endtask

    initial begin
        clr = 1'b1; irq = '0; int_ack = 0; iret = 0; ei = 0; di = 0;
        mask_we = 0; mask_wdata = '0;
        m_reset();
        #3;
        reset_consts("rst");
        clr = 1'b0;
        @(posedge t3); #1;

        // Single source
        mask_wdata = 4'b1110; mask_we = 1; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000;
        chk("single_req", 32'(int_req), 32'd1);
        chk("single_vec", 32'(int_vec), 32'hE0);
        chk("single_id", 32'(int_id), 32'd0);
        int_ack = 1; tick();
        chk("single_en", 32'(en_int), 32'd0);
        chk("single_isv", 32'(in_service), 32'b0001);
        chk("single_pend", 32'(pending), 32'd0);
        iret = 1; tick();
        chk("single_ret_en", 32'(en_int), 32'd1);
        chk("single_ret_depth", 32'(nest_depth), 32'd0);

        // Priority
        mask_wdata = 4'b0000; mask_we = 1; tick();
        irq = 4'b1010; tick();
        irq = 4'b0000;
        chk("prio_vec1", 32'(int_vec), 32'hE4);
        chk("prio_id1", 32'(int_id), 32'd1);
        int_ack = 1; tick();
        iret = 1; tick();
        chk("prio_vec3", 32'(int_vec), 32'hEC);
        chk("prio_id3", 32'(int_id), 32'd3);
        int_ack = 1; tick();
        iret = 1; tick();

        // Nesting
        irq = 4'b0100; tick();
        irq = 4'b0000; int_ack = 1; tick();
        ei = 1; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000;
        chk("nest_req", 32'(int_req), 32'd1);
        chk("nest_vec", 32'(int_vec), 32'hE0);
        int_ack = 1; tick();
        chk("nest_depth2", 32'(nest_depth), 32'd2);
        chk("nest_isv", 32'(in_service), 32'b0101);
        irq = 4'b0010; tick();
        irq = 4'b0000; tick();
        chk("nest_full_req", 32'(int_req), 32'd0);
        iret = 1; tick();
        iret = 1; tick();
        chk("nest_after_id", 32'(int_id), 32'd1);
        chk("nest_after_req", 32'(int_req), 32'd1);
        int_ack = 1; tick();
        iret = 1; tick();

        // Mask and level
        mask_wdata = 4'b0100; mask_we = 1; tick();
        irq = 4'b0100;
        for (int i = 0; i < 10; i++) tick();
        chk("level_pend", 32'(pending), 32'b0100);
        chk("level_req", 32'(int_req), 32'd0);
        irq = 4'b0000; mask_wdata = 4'b0000; mask_we = 1; tick();
        chk("unmask_id", 32'(int_id), 32'd2);
        chk("unmask_req", 32'(int_req), 32'd1);
        int_ack = 1; tick();
        chk("unmask_pend", 32'(pending), 32'd0);
        iret = 1; tick();

        // Enable control
        di = 1; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000;
        chk("en_off_req", 32'(int_req), 32'd0);
        ei = 1; di = 1; tick();
        chk("ei_di_en", 32'(en_int), 32'd0);
        ei = 1; tick();
        chk("ei_req", 32'(int_req), 32'd1);
        int_ack = 1; tick();
        iret = 1; tick();

        // Async reset mid-service
        irq = 4'b0001; tick();
        irq = 4'b0000; int_ack = 1; tick();
        chk("pre_rst_depth", 32'(nest_depth), 32'd1);
        #2 clr = 1'b1;
        #1 reset_consts("arst");
        m_reset();
        tick();
        clr = 1'b0;
        irq = 4'b0001; tick();
        irq = 4'b0000; tick();
        chk("post_rst_req", 32'(int_req), 32'd0);

        // Randomised traffic against the reference model
        mask_wdata = 4'b0000; mask_we = 1; tick();
        for (int n = 0; n < 400; n++) begin
            irq        = 4'($urandom);
            int_ack    = ($urandom_range(0, 1) == 0);
            iret       = ($urandom_range(0, 5) == 0);
            ei         = ($urandom_range(0, 7) == 0);
            di         = ($urandom_range(0, 7) == 0);
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = 4'($urandom);
            tick();
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_vec_ctrl.md
Name: int_vec_ctrl

Overview:
- Parametrised successor to the CPU sequencer's single-source interrupt flag logic (int0 / en_int / st1).
- Accepts NUM_SRC edge-triggered sources with per-source mask, fixed priority, vectored entry and nesting up to NEST_DEPTH levels.
- Sits beside the hardwired sequencer: raises int_req, supplies the target PC, and is handshaken by int_ack (interrupt W1) and iret (IRET W3).

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8); index 0 is highest priority.
- NEST_DEPTH, 2, maximum in-service nesting levels (1..4).
- ADDR_W, 8, PC/vector width.
- VEC_BASE, 8'hE0, vector of source 0.
- VEC_STRIDE, 4, address spacing between consecutive source vectors.

Ports:
- t3  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous reset, active-high.
- irq  in  NUM_SRC  request lines, synchronous to t3; a rising edge requests.
- int_ack  in  1  sequencer accepts the current int_req (one cycle).
- iret  in  1  return-from-interrupt executed (one cycle).
- ei  in  1  set global enable.
- di  in  1  clear global enable.
- mask_we  in  1  write strobe for mask.
- mask_wdata  in  NUM_SRC  new mask; 1 = source masked.
- int_req  out  1  interrupt should be taken.
- int_vec  out  ADDR_W  entry PC for the winning source.
- int_id  out  3  winning source index.
- en_int  out  1  global enable.
- pending  out  NUM_SRC  latched requests.
- in_service  out  NUM_SRC  sources currently being serviced.
- nest_depth  out  3  number of stack entries in use.

Behaviour:
- Reset (clr=1, async) values:
  - pending=0, in_service=0, mask=all 1s, en_int=1, stack empty, nest_depth=0, irq_q=0.
  - Outputs are derived from this state, so int_req=0, int_vec=VEC_BASE, int_id=0.
- Edge detect:
  - irq_q registers irq every cycle.
  - irq[i] & ~irq_q[i] sets pending[i] on the next edge.
  - A level held high produces exactly one request.
- Candidate selection (combinational from registers):
  - cand = lowest index i with pending[i] & ~mask[i].
  - cand_valid = any such i.
- Preemption:
  - Allowed when the stack is empty, or when cand < top-of-stack id (strictly higher priority).
  - Equal or lower priority waits.
- int_req = en_int & cand_valid & preempt_ok & (nest_depth < NEST_DEPTH).
  - Combinational, no added latency: a request edge at cycle n gives pending at n+1, so int_req is high during cycle n+1.
- int_id = cand.
- int_vec = VEC_BASE + cand*VEC_STRIDE, truncated to ADDR_W. Only meaningful while int_req=1.
- int_ack while int_req=1, on the next edge:
  - pending[cand] cleared; it stays set if a new edge on irq[cand] arrives in the same cycle.
  - cand pushed onto the stack; in_service[cand] set; nest_depth+1.
  - en_int cleared.
- int_ack while int_req=0: ignored, no state change.
- iret, on the next edge:
  - Pop the top entry, clear its in_service bit, nest_depth-1, set en_int.
  - With an empty stack: only set en_int.
- En_int update priority within one cycle (highest first):
  - accepted int_ack → 0
  - di → 0
  - iret or ei → 1
  - else hold
- iret and int_ack in the same cycle: iret is processed, int_ack is ignored. This is a sequencer protocol error and must not corrupt the stack.
- mask_we: mask ← mask_wdata on the next edge. Pending bits are unaffected; a masked pending bit stays latched and fires once unmasked.
- Stack full (nest_depth=NEST_DEPTH): int_req is forced 0; pending bits are retained.
- Reset mid-service: all state returns to reset values immediately. Outstanding requests are lost.

Test Plan:
- Single source: reset, mask_wdata=4'b1110 with mask_we, pulse irq[0] → int_req=1 one cycle after the edge, int_vec=8'hE0, int_id=0; int_ack → en_int=0, in_service=0001, pending=0; iret → en_int=1, nest_depth=0.
- Priority: unmask all, raise irq[3] and irq[1] in the same cycle → int_vec=8'hE4 (id 1); ack, then iret → int_vec=8'hEC (id 3).
- Nesting: service id 2 with ack, issue ei, pulse irq[0] → int_req=1, vector 8'hE0; ack → nest_depth=2, in_service=0101; pulse irq[1] → int_req stays 0 (stack full); iret twice → id 1 serviced afterwards.
- Mask and level: irq[2] held high for 10 cycles while masked → pending[2]=1 only once, int_req=0; unmask → exactly one request; after ack, pending[2]=0.
- Enable control: set pending[0] with en_int=0 → int_req=0; assert ei and di in the same cycle → en_int stays 0; ei alone → int_req=1 next cycle.
- Async reset: assert clr mid-service (nest_depth=1) between clock edges → all outputs at reset values immediately; deassert, pulse irq[0] while masked → no int_req.
